// File: rtl/rr_switch_control.sv
// Control unit for a mesh switch: one-flit input slots, one round-robin arbiter per output.
// Drives the input FIFO read strobes, the output FIFO write strobes and the crossbar selects.
module rr_switch_control #(
    parameter int unsigned PORT_N    = 5,
    parameter bit          BYPASS_RD = 1'b0,
    parameter int unsigned SEL_W     = $clog2(PORT_N)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [PORT_N-1:0]         empty_i,
    output logic [PORT_N-1:0]         rd_en_o,
    output logic [PORT_N-1:0]         vld_input_o,
    input  logic [PORT_N*SEL_W-1:0]   dest_i,
    input  logic [PORT_N-1:0]         full_i,
    output logic [PORT_N-1:0]         wr_en_o,
    output logic [PORT_N*SEL_W-1:0]   mux_sel_o,
    output logic                      dest_err_o
);

    logic [PORT_N-1:0]             vld;
    logic [PORT_N-1:0]             drain;
    logic [PORT_N-1:0]             bad_drop;
    logic                          bad_found;
    logic                          dest_err_q;
    logic                          multi_gnt;
    logic [PORT_N-1:0][PORT_N-1:0] req;
    logic [PORT_N-1:0]             has_req;
    logic [PORT_N-1:0]             found;
    logic [SEL_W-1:0]              ptr  [PORT_N];
    logic [SEL_W-1:0]              gsel [PORT_N];
    int unsigned                   idx;

    // Requests per output; an out-of-range destination drops only the lowest such input per cycle.
    always_comb begin
        req       = '0;
        bad_drop  = '0;
        bad_found = 1'b0;
        for (int unsigned i = 0; i < PORT_N; i++) begin
            for (int unsigned j = 0; j < PORT_N; j++) begin
                req[j][i] = vld[i] && (dest_i[i*SEL_W +: SEL_W] == SEL_W'(j));
            end
            if (vld[i] && (32'(dest_i[i*SEL_W +: SEL_W]) >= PORT_N) && !bad_found) begin
                bad_drop[i] = 1'b1;
                bad_found   = 1'b1;
            end
        end
    end

    // Cyclic search starting at ptr[j]
    always_comb begin
        has_req = '0;
        found   = '0;
        idx     = 0;
        for (int unsigned j = 0; j < PORT_N; j++) begin
            gsel[j]    = '0;
            has_req[j] = |req[j];
            for (int unsigned k = 0; k < PORT_N; k++) begin
                idx = 32'(ptr[j]) + k;
                if (idx >= PORT_N) idx = idx - PORT_N;
                if (!found[j] && req[j][idx]) begin
                    found[j] = 1'b1;
                    gsel[j]  = SEL_W'(idx);
                end
            end
        end
    end

    always_comb begin
        wr_en_o   = '0;
        mux_sel_o = '0;
        rd_en_o   = '0;
        drain     = bad_drop;
        multi_gnt = 1'b0;
        for (int unsigned j = 0; j < PORT_N; j++) begin
            if (rst_ni && has_req[j] && !full_i[j]) begin
                wr_en_o[j]                    = 1'b1;
                mux_sel_o[j*SEL_W +: SEL_W]   = gsel[j];
                if (drain[gsel[j]]) multi_gnt = 1'b1;
                drain[gsel[j]]                = 1'b1;
            end
        end
        for (int unsigned i = 0; i < PORT_N; i++) begin
            rd_en_o[i] = rst_ni && !empty_i[i] && (!vld[i] || (BYPASS_RD && drain[i]));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld        <= '0;
            dest_err_q <= 1'b0;
            for (int unsigned j = 0; j < PORT_N; j++) ptr[j] <= '0;
        end else begin
            vld        <= rd_en_o | (vld & ~drain);
            dest_err_q <= |bad_drop;
            for (int unsigned j = 0; j < PORT_N; j++) begin
                if (wr_en_o[j]) begin
                    ptr[j] <= (gsel[j] == SEL_W'(PORT_N-1)) ? '0 : gsel[j] + SEL_W'(1);
                end
            end
        end
    end

    assign vld_input_o = vld;
    assign dest_err_o  = dest_err_q;

    for (genvar g = 0; g < PORT_N; g++) begin : g_chk
        a_no_refill: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (vld[g] && rd_en_o[g]) |-> (BYPASS_RD && drain[g]));
        a_full:      assert property (@(posedge clk_i) disable iff (!rst_ni)
            full_i[g] |-> !wr_en_o[g]);
        a_empty:     assert property (@(posedge clk_i) disable iff (!rst_ni)
            empty_i[g] |-> !rd_en_o[g]);
    end
    a_one_grant: assert property (@(posedge clk_i) disable iff (!rst_ni) !multi_gnt);

endmodule

// File: tb/tb_rr_switch_control.sv
// Directed bench for rr_switch_control: a queue of expected (output, source) writes is
// pushed as flits are offered and popped per output as writes appear.
module tb_rr_switch_control;
    localparam int N = 5;
    localparam int W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N-1:0]   empty, full, rd, vld, wr;
    logic [N*W-1:0] dest, sel;
    logic           err;
    logic [N-1:0]   empty_b, full_b, rd_b, vld_b, wr_b;
    logic [N*W-1:0] dest_b, sel_b;
    logic           err_b;

    rr_switch_control #(.PORT_N(N), .BYPASS_RD(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .empty_i(empty), .rd_en_o(rd), .vld_input_o(vld),
        .dest_i(dest), .full_i(full), .wr_en_o(wr), .mux_sel_o(sel), .dest_err_o(err));

    rr_switch_control #(.PORT_N(N), .BYPASS_RD(1'b1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .empty_i(empty_b), .rd_en_o(rd_b), .vld_input_o(vld_b),
        .dest_i(dest_b), .full_i(full_b), .wr_en_o(wr_b), .mux_sel_o(sel_b), .dest_err_o(err_b));

    typedef struct { int out; int src; } wr_t;
    wr_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cnt [N];
    int cnt_b [N];
    int cyc = 0;
    int start = 0;
    int nb = 0, first_b = -1, last_b = -1, last_m = -1;
    logic [N-1:0]   l_rd, l_vld, l_wr;
    logic [N*W-1:0] l_sel;
    logic           l_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int o, input int s);
        wr_t e;
        e.out = o;
        e.src = s;
        exp_q.push_back(e);
    endtask

    task automatic set_dest(input int i, input int d);
        dest[i*W +: W] = W'(d);
    endtask

    task automatic sb_check();
        for (int j = 0; j < N; j++) begin
            if (wr[j]) begin
                int k;
                k = -1;
                for (int q = 0; q < exp_q.size(); q++)
                    if (exp_q[q].out == j && k < 0) k = q;
                if (k >= 0) begin
                    chk($sformatf("sb_out%0d_src", j), 32'(sel[j*W +: W]), exp_q[k].src);
                    exp_q.delete(k);
                end else begin
                    chk($sformatf("sb_unexpected_wr%0d", j), 32'(wr[j]), 0);
                end
            end
        end
    endtask

    // One clock: drive FIFO flags from the occupancy model, sample at negedge, consume reads.
    task automatic cycle();
        for (int i = 0; i < N; i++) begin
            empty[i]   = (cnt[i] == 0);
            empty_b[i] = (cnt_b[i] == 0);
        end
        @(negedge clk);
        l_rd = rd; l_vld = vld; l_wr = wr; l_sel = sel; l_err = err;
        sb_check();
        if (wr[0]) last_m = cyc;
        if (wr_b[0]) begin
            nb++;
            if (first_b < 0) first_b = cyc;
            last_b = cyc;
        end
        for (int i = 0; i < N; i++) begin
            if (rd[i])   cnt[i]--;
            if (rd_b[i]) cnt_b[i]--;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst_n = 1'b0; full = '0; dest = '0; full_b = '0; dest_b = '0;
        for (int i = 0; i < N; i++) begin cnt[i] = 0; cnt_b[i] = 0; end
        cycle(); cycle();
        chk("rst_vld", 32'(l_vld), 0);
        chk("rst_err", 32'(l_err), 0);

        // Idle
        rst_n = 1'b1;
        cycle();
        chk("idle_rd", 32'(l_rd), 0);
        chk("idle_wr", 32'(l_wr), 0);
        chk("idle_vld", 32'(l_vld), 0);

        // Reset with three slots held
        full = '1; cnt[0] = 1; cnt[1] = 1; cnt[2] = 1;
        set_dest(0, 1); set_dest(1, 2); set_dest(2, 3);
        cycle();
        chk("load_rd", 32'(l_rd), 'h07);
        cycle();
        chk("load_vld", 32'(l_vld), 'h07);
        chk("load_wr_full", 32'(l_wr), 0);
        rst_n = 1'b0; full = '0; cnt[3] = 1;
        cycle();
        chk("inrst_rd", 32'(l_rd), 0);
        chk("inrst_wr", 32'(l_wr), 0);
        chk("inrst_sel", 32'(l_sel), 0);
        chk("inrst_vld_pre", 32'(l_vld), 'h07);
        cycle();
        chk("rst_clear_vld", 32'(l_vld), 0);
        cnt[3] = 0; rst_n = 1'b1;
        cycle();
        chk("post_rst_wr", 32'(l_wr), 0);

        // Single path 1 -> 3
        set_dest(1, 3); cnt[1] = 1; push(3, 1);
        cycle();
        chk("single_rd", 32'(l_rd), 'h02);
        chk("single_wr0", 32'(l_wr), 0);
        cycle();
        chk("single_vld", 32'(l_vld), 'h02);
        chk("single_wr", 32'(l_wr), 'h08);
        chk("single_sel3", 32'(l_sel[3*W +: W]), 1);
        cycle();
        chk("single_vld_clr", 32'(l_vld), 0);

        // Contention on output 2 from inputs 0, 2, 4
        set_dest(0, 2); set_dest(2, 2); set_dest(4, 2);
        cnt[0] = 2; cnt[2] = 2; cnt[4] = 2;
        push(2, 0); push(2, 2); push(2, 4); push(2, 0); push(2, 2); push(2, 4);
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) cycle();
        chk("contention_done", exp_q.size(), 0);
        cycle();

        // Concurrency 0 -> 1 and 3 -> 4
        set_dest(0, 1); set_dest(3, 4); cnt[0] = 1; cnt[3] = 1;
        push(1, 0); push(4, 3);
        cycle();
        chk("conc_rd", 32'(l_rd), 'h09);
        cycle();
        chk("conc_wr", 32'(l_wr), 'h12);
        chk("conc_sel", 32'(l_sel), 'h3000);

        // Backpressure on output 0; input 1 -> 3 proceeds
        full[0] = 1'b1; set_dest(2, 0); cnt[2] = 2; set_dest(1, 3); cnt[1] = 1;
        push(3, 1);
        cycle();
        chk("bp_rd", 32'(l_rd), 'h06);
        cycle();
        chk("bp_other_wr", 32'(l_wr), 'h08);
        chk("bp_vld", 32'(l_vld), 'h06);
        for (int t = 0; t < 2; t++) begin
            cycle();
            chk("bp_hold_vld", 32'(l_vld[2]), 1);
            chk("bp_hold_rd", 32'(l_rd[2]), 0);
            chk("bp_hold_wr", 32'(l_wr), 0);
        end
        full[0] = 1'b0; push(0, 2); push(0, 2);
        cycle();
        chk("bp_release_wr", 32'(l_wr), 'h01);
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) cycle();
        chk("bp_done", exp_q.size(), 0);
        cycle();

        // Single bad destination
        set_dest(1, 6); cnt[1] = 1;
        cycle();
        chk("bad_rd", 32'(l_rd), 'h02);
        cycle();
        chk("bad_vld", 32'(l_vld), 'h02);
        chk("bad_wr", 32'(l_wr), 0);
        chk("bad_err0", 32'(l_err), 0);
        cycle();
        chk("bad_err1", 32'(l_err), 1);
        chk("bad_vld_clr", 32'(l_vld), 0);
        cycle();
        chk("bad_err_end", 32'(l_err), 0);

        // Two bad destinations: lowest first, one per cycle
        set_dest(3, 5); cnt[1] = 1; cnt[3] = 1;
        cycle();
        cycle();
        chk("bad2_vld", 32'(l_vld), 'h0a);
        cycle();
        chk("bad2_order", 32'(l_vld), 'h08);
        chk("bad2_err_a", 32'(l_err), 1);
        cycle();
        chk("bad2_err_b", 32'(l_err), 1);
        cycle();
        chk("bad2_err_end", 32'(l_err), 0);

        // Streaming 8 flits 4 -> 0 on both instances
        set_dest(4, 0); dest_b[4*W +: W] = 3'd0;
        cnt[4] = 8; cnt_b[4] = 8;
        for (int f = 0; f < 8; f++) push(0, 4);
        start = cyc; last_m = -1; nb = 0; first_b = -1; last_b = -1;
        for (int c = 0; c < 20; c++) cycle();
        chk("byp_pulses", nb, 8);
        chk("byp_consec", last_b - first_b, 7);
        chk("byp_first", first_b - start, 1);
        chk("nobyp_span", last_m - start + 1, 16);
        chk("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
